// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision constants and types.
// Reused by the float datapath blocks.
package float_pkg;

    localparam int FLT_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int SIGN_BIT = 31;
    localparam int EXP_LSB  = FRAC_W;
    localparam int EXP_MSB  = FRAC_W + EXP_W - 1;

    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
    localparam logic [EXP_W-1:0] EXP_2P31 = EXP_W'(FLT_BIAS + 31);

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/float_unpack.sv
// Combinational split of a single-precision float into fields,
// unbiased exponent and class bits.
module float_unpack
    import float_pkg::*;
(
    input  logic [31:0]       f,
    output logic              sign,
    output logic [EXP_W-1:0]  biased_exp,
    output logic [FRAC_W-1:0] frac,
    output logic signed [8:0] e,
    output logic              is_nan,
    output logic              is_inf,
    output logic              is_zero,
    output logic              is_denorm
);

    logic exp_max;
    logic exp_min;
    logic frac_nz;

    assign sign       = f[SIGN_BIT];
    assign biased_exp = f[EXP_MSB:EXP_LSB];
    assign frac       = f[FRAC_W-1:0];
    assign e          = $signed({1'b0, biased_exp}) - 9'(FLT_BIAS);

    assign exp_max = (biased_exp == EXP_ALL1);
    assign exp_min = (biased_exp == '0);
    assign frac_nz = (frac != '0);

    assign is_nan    = exp_max & frac_nz;
    assign is_inf    = exp_max & ~frac_nz;
    assign is_zero   = exp_min & ~frac_nz;
    assign is_denorm = exp_min & frac_nz;

endmodule

// File: rtl/float_to_int.sv
// Float to signed 32-bit integer, truncating toward zero with a
// one-bit-per-cycle shifter behind valid/ready handshakes.
module float_to_int
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    logic              u_sign;
    logic [EXP_W-1:0]  u_exp;
    logic [FRAC_W-1:0] u_frac;
    logic signed [8:0] u_e;
    logic              u_nan;
    logic              u_inf;
    logic              u_zero;
    logic              u_denorm;

    float_unpack u_unpack (
        .f          (in_data),
        .sign       (u_sign),
        .biased_exp (u_exp),
        .frac       (u_frac),
        .e          (u_e),
        .is_nan     (u_nan),
        .is_inf     (u_inf),
        .is_zero    (u_zero),
        .is_denorm  (u_denorm)
    );

    state_t      state_q, state_d;
    logic [31:0] mant_q, mant_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        sign_q, sign_d;
    logic        sticky_q, sticky_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  flags_q, flags_d;

    logic        sh_left;
    logic [4:0]  sh_cnt;

    // Valid only for 0 <= e <= 30, the range that reaches the shifter.
    assign sh_left = (u_e[4:0] > 5'd23);
    assign sh_cnt  = sh_left ? (u_e[4:0] - 5'd23)
                             : (5'd23 - u_e[4:0]);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_flags = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mant_q   <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            data_q   <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        data_d   = data_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = u_sign;
                    sticky_d = 1'b0;
                    mant_d   = {8'd0, ~(u_zero | u_denorm), u_frac};
                    cnt_d    = '0;
                    state_d  = DONE;
                    if (u_nan) begin
                        data_d  = '0;
                        flags_d = 3'b100;
                    end else if (u_inf || u_e > 9'sd30) begin
                        // -2^31 is the one representable value here.
                        if (u_sign && u_exp == EXP_2P31
                            && u_frac == '0) begin
                            data_d  = INT_MIN;
                            flags_d = 3'b000;
                        end else begin
                            data_d  = u_sign ? INT_MIN : INT_MAX;
                            flags_d = 3'b010;
                        end
                    end else if (u_e < 9'sd0) begin
                        data_d  = '0;
                        flags_d = {2'b00, ~u_zero};
                    end else begin
                        left_d  = sh_left;
                        cnt_d   = sh_cnt;
                        state_d = (sh_cnt == '0) ? FIX : SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mant_d = {mant_q[30:0], 1'b0};
                end else begin
                    mant_d   = {1'b0, mant_q[31:1]};
                    sticky_d = sticky_q | mant_q[0];
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                data_d  = sign_q ? -mant_q : mant_q;
                flags_d = {2'b00, sticky_q};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_float_to_int.sv
// Directed self-checking bench for float_to_int.
// Hand-computed vectors, latency, back-pressure and reset checks.
module tb_float_to_int;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int n_vec;
    int n_err;

    float_to_int dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] f,
                           input logic [31:0] exp_data,
                           input logic [2:0] exp_flags,
                           input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data"}, out_data, exp_data);
        chk({tag, " flags"}, {29'd0, out_flags}, {29'd0, exp_flags});
        chk({tag, " busy"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, " hold data"}, out_data, exp_data);
            chk({tag, " hold ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " release valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " release ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int stray;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst out_flags", {29'd0, out_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready ignored", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        convert("5.5",    32'h40B0_0000, 32'd5,         3'b001, 23, 0);
        convert("-1.0",   32'hBF80_0000, 32'hFFFF_FFFF, 3'b000, 25, 0);
        convert("2^23+1", 32'h4B00_0001, 32'd8388609,   3'b000, 2,  0);
        convert("2^31",   32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1,  0);
        convert("-2^31",  32'hCF00_0000, 32'h8000_0000, 3'b000, 1,  0);
        convert("-2^31-", 32'hCF00_0001, 32'h8000_0000, 3'b010, 1,  0);
        convert("-inf",   32'hFF80_0000, 32'h8000_0000, 3'b010, 1,  0);
        convert("+inf",   32'h7F80_0000, 32'h7FFF_FFFF, 3'b010, 1,  0);
        convert("nan",    32'h7FC0_0000, 32'd0,         3'b100, 1,  0);
        convert("0.5",    32'h3F00_0000, 32'd0,         3'b001, 1,  0);
        convert("zero",   32'h0000_0000, 32'd0,         3'b000, 1,  0);
        convert("denorm", 32'h0000_0001, 32'd0,         3'b001, 1,  0);
        convert("maxpos", 32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 9,  0);
        convert("maxneg", 32'hCEFF_FFFF, 32'h8000_0080, 3'b000, 9,  0);
        convert("-1.5",   32'hBFC0_0000, 32'hFFFF_FFFF, 3'b001, 25, 0);
        convert("123bp",  32'h42F6_0000, 32'd123,       3'b000, 19, 5);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst out_data", out_data, 32'd0);
        chk("midrst out_flags", {29'd0, out_flags}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        chk("midrst stray valid", stray, 32'd0);
        chk("midrst ready after", {31'd0, in_ready}, 32'd1);
        convert("2.0", 32'h4000_0000, 32'd2, 3'b000, 24, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
